// File: rtl/img_pkg.sv
// img_pkg: shared constants and state encodings for the image output path.
// Also used by the mapping controller, so keep encodings stable.
package img_pkg;
  localparam int LINE_W        = 128;  // bits per output-memory line
  localparam int PIX_W         = 8;    // bits per pixel
  localparam int PIX_PER_LINE  = 16;   // pixels per line
  localparam int NUM_LINES_DEF = 64;   // default lines per frame
  localparam int LINE_CNT_W    = 7;    // line counter width (zero-extended to address)
  localparam int IDX_W         = $clog2(PIX_PER_LINE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } top_state_t;

  typedef enum logic {
    F_IDLE = 1'b0,
    F_WAIT = 1'b1   // a read is in flight; doubles as the read-pending flag
  } fetch_state_t;
endpackage

// File: rtl/img_line_fetch.sv
// img_line_fetch: issues one output-memory line read at a time, counts the
// read latency and presents the returned line for one cycle.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   run            frame in progress (reads allowed)
//   clear          top idle: rewind the line counter to 0
//   next_full      second buffer occupied: hold off further reads
//   rd_addr/rd_en  memory read address / one-cycle strobe
//   rd_data        memory read data
//   line_data      returned line (valid with line_valid)
//   line_valid     capture strobe, RD_LATENCY cycles after the issue cycle
module img_line_fetch
  import img_pkg::*;
#(
  parameter int NUM_LINES  = NUM_LINES_DEF,
  parameter int RD_LATENCY = 2,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              clear,
  input  logic              next_full,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [LINE_W-1:0] rd_data,
  output logic [LINE_W-1:0] line_data,
  output logic              line_valid
);
  localparam int CW = $clog2(RD_LATENCY + 1);

  fetch_state_t          fstate;
  logic [CW-1:0]         lat_cnt;
  logic [LINE_CNT_W-1:0] fetch_line;
  logic                  issue;

  // Only one read in flight, and only when the landing spot is guaranteed:
  // the next buffer is empty, so the capture can never be dropped.
  assign issue = run && (fstate == F_IDLE) && !next_full &&
                 (fetch_line < LINE_CNT_W'(NUM_LINES));

  assign rd_en      = issue;
  assign rd_addr    = ADDR_W'(fetch_line);
  assign line_data  = rd_data;
  assign line_valid = (fstate == F_WAIT) && (lat_cnt == CW'(RD_LATENCY));

  always_ff @(posedge clk) begin
    if (reset) begin
      fstate     <= F_IDLE;
      lat_cnt    <= '0;
      fetch_line <= '0;
    end else begin
      case (fstate)
        F_IDLE: begin
          if (issue) begin
            fstate     <= F_WAIT;
            lat_cnt    <= CW'(1);
            fetch_line <= fetch_line + 1'b1;
          end else if (clear) begin
            fetch_line <= '0;
          end
        end
        F_WAIT: begin
          if (lat_cnt == CW'(RD_LATENCY)) begin
            fstate  <= F_IDLE;
            lat_cnt <= '0;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        default: fstate <= F_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/img_out_stream.sv
// img_out_stream: after output_wt_done, reads NUM_LINES 128-bit lines from
// output memory (address 0 up) and streams them as 8-bit pixels, LSB byte
// first, over valid/ready. A line buffer plus a one-line prefetch (next)
// buffer keep a continuously-ready sink bubble-free.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   output_wt_done              frame start pulse (honoured only in IDLE)
//   out_mem_rd_addr/_en/_data   output memory read port
//   pix_data/_valid/_ready      pixel stream
//   pix_eol, pix_last           last pixel of line / of frame (with valid)
//   stream_busy, stream_done    frame in progress / one-cycle end pulse
module img_out_stream
  import img_pkg::*;
#(
  parameter int NUM_LINES  = NUM_LINES_DEF,
  parameter int RD_LATENCY = 2,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              output_wt_done,
  output logic [ADDR_W-1:0] out_mem_rd_addr,
  output logic              out_mem_rd_en,
  input  logic [LINE_W-1:0] out_mem_rd_data,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_eol,
  output logic              pix_last,
  output logic              stream_busy,
  output logic              stream_done
);
  top_state_t            state;
  logic [LINE_W-1:0]     line_buf, next_buf;
  logic                  line_full, next_full;
  logic [IDX_W-1:0]      pix_idx;
  logic [LINE_CNT_W-1:0] out_line;   // index of the line being serialised

  logic [LINE_W-1:0]     line_data;
  logic                  line_valid;
  logic                  xfer, last_px, cap_line, cap_next;

  img_line_fetch #(
    .NUM_LINES (NUM_LINES),
    .RD_LATENCY(RD_LATENCY),
    .ADDR_W    (ADDR_W)
  ) u_fetch (
    .clk       (clk),
    .reset     (reset),
    .run       (state == S_RUN),
    .clear     (state == S_IDLE),
    .next_full (next_full),
    .rd_addr   (out_mem_rd_addr),
    .rd_en     (out_mem_rd_en),
    .rd_data   (out_mem_rd_data),
    .line_data (line_data),
    .line_valid(line_valid)
  );

  assign pix_valid   = line_full;
  assign pix_data    = line_full ? line_buf[PIX_W-1:0] : '0;
  assign pix_eol     = line_full && (pix_idx == IDX_W'(PIX_PER_LINE - 1));
  assign pix_last    = pix_eol && (out_line == LINE_CNT_W'(NUM_LINES - 1));
  assign stream_busy = (state != S_IDLE);
  assign stream_done = (state == S_DONE);

  assign xfer    = line_full && pix_ready;
  assign last_px = xfer && pix_eol;

  // A returning line goes straight to the serialiser if it is empty or is
  // handing off its final pixel this cycle; otherwise it is parked.
  assign cap_line = line_valid && (!line_full || last_px);
  assign cap_next = line_valid && !cap_line;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      line_buf  <= '0;
      next_buf  <= '0;
      line_full <= 1'b0;
      next_full <= 1'b0;
      pix_idx   <= '0;
      out_line  <= '0;
    end else begin
      case (state)
        S_IDLE: if (output_wt_done) begin
          state    <= S_RUN;
          out_line <= '0;
        end
        S_RUN:  if (xfer && pix_last) state <= S_DONE;
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (last_px) out_line <= out_line + 1'b1;

      // Serialiser: shift right so the current pixel is always byte 0.
      if (cap_line) begin
        line_buf  <= line_data;
        line_full <= 1'b1;
        pix_idx   <= '0;
      end else if (last_px) begin
        pix_idx <= '0;
        if (next_full) begin
          line_buf  <= next_buf;
          next_full <= 1'b0;
        end else begin
          line_full <= 1'b0;
        end
      end else if (xfer) begin
        line_buf <= line_buf >> PIX_W;
        pix_idx  <= pix_idx + 1'b1;
      end

      if (cap_next) begin
        next_buf  <= line_data;
        next_full <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_img_out_stream.sv
module tb_img_out_stream;
  localparam int NL   = 64;
  localparam int RL   = 2;
  localparam int AW   = 16;
  localparam int NPIX = NL * 16;

  logic          clk = 1'b0;
  logic          reset, output_wt_done, pix_ready;
  logic [AW-1:0] out_mem_rd_addr;
  logic          out_mem_rd_en;
  logic [127:0]  out_mem_rd_data;
  logic [7:0]    pix_data;
  logic          pix_valid, pix_eol, pix_last, stream_busy, stream_done;

  always #5 clk = ~clk;

  img_out_stream #(.NUM_LINES(NL), .RD_LATENCY(RL), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .output_wt_done(output_wt_done),
    .out_mem_rd_addr(out_mem_rd_addr), .out_mem_rd_en(out_mem_rd_en),
    .out_mem_rd_data(out_mem_rd_data), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_eol(pix_eol),
    .pix_last(pix_last), .stream_busy(stream_busy), .stream_done(stream_done)
  );

  // Memory model: data for the address presented in cycle c is on the bus
  // in cycle c+RL.
  logic [127:0] mem [NL];
  logic [127:0] dp  [RL];
  always @(posedge clk) begin
    dp[0] <= mem[out_mem_rd_addr[5:0]];
    for (int i = 1; i < RL; i++) dp[i] <= dp[i-1];
  end
  assign out_mem_rd_data = dp[RL-1];

  int total = 0, passed = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr"},  out_mem_rd_addr, 0);
    check({tag, "_rden"},  out_mem_rd_en, 0);
    check({tag, "_data"},  pix_data, 0);
    check({tag, "_valid"}, pix_valid, 0);
    check({tag, "_eol"},   pix_eol, 0);
    check({tag, "_last"},  pix_last, 0);
    check({tag, "_busy"},  stream_busy, 0);
    check({tag, "_done"},  stream_done, 0);
  endtask

  task automatic fill_pattern();
    for (int n = 0; n < NL; n++)
      for (int k = 0; k < 16; k++) mem[n][8*k +: 8] = 8'((16*n + k) % 256);
  endtask

  task automatic fill_random();
    for (int n = 0; n < NL; n++) mem[n] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // mode: 0 always ready, 1 stall cycles 10..60, 2 random ready,
  //       3 reset at pixel 300, 4 spurious starts in RUN and DONE
  task automatic run_frame(input int mode);
    int cyc, exp_idx, rd_cnt, lines_done, done_cnt, last_cyc, first_cyc, bad;
    bit prev_valid, prev_ready, rdy;
    logic [7:0]   prev_data, eb;
    logic [127:0] ln;
    exp_idx = 0; rd_cnt = 0; lines_done = 0; done_cnt = 0; bad = 0;
    last_cyc = -1; first_cyc = -1; prev_valid = 0; prev_ready = 0; prev_data = '0;
    @(negedge clk);
    output_wt_done = 1'b1; pix_ready = 1'b0; cyc = 0;
    while (done_cnt == 0 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      output_wt_done = (mode == 4 && cyc == 100);
      check("busy", stream_busy, 1);
      if (out_mem_rd_en) begin
        check("rd_addr", out_mem_rd_addr, rd_cnt);
        rd_cnt++;
        check("outstanding_le2", (rd_cnt - lines_done) <= 2, 1);
      end
      if (pix_valid && first_cyc < 0) begin
        first_cyc = cyc;
        check("first_valid_cyc", cyc, 4);
      end
      if (prev_valid && !prev_ready) begin
        check("stall_valid", pix_valid, 1);
        check("stall_data", pix_data, prev_data);
      end
      if (mode == 0 && first_cyc >= 0 && exp_idx < NPIX) check("contig_valid", pix_valid, 1);
      if (mode == 3 && exp_idx == 300 && pix_valid) begin
        reset = 1'b1; pix_ready = 1'b0;
        @(negedge clk);
        check_zero("after_reset");
        reset = 1'b0;
        return;
      end
      case (mode)
        1:       rdy = !(cyc >= 10 && cyc <= 60);
        2:       rdy = ($urandom_range(0, 1) == 1);
        default: rdy = 1'b1;
      endcase
      pix_ready = rdy;
      if (pix_valid && rdy) begin
        ln = mem[exp_idx / 16];
        eb = ln[(exp_idx % 16) * 8 +: 8];
        check("pix_data", pix_data, eb);
        check("pix_eol", pix_eol, (exp_idx % 16) == 15);
        check("pix_last", pix_last, exp_idx == NPIX - 1);
        if (exp_idx % 16 == 15) lines_done++;
        exp_idx++;
        if (exp_idx == NPIX) last_cyc = cyc;
      end
      if (stream_done) begin
        check("done_cycle", cyc, last_cyc + 1);
        done_cnt++;
        output_wt_done = (mode == 4);
      end
      prev_valid = pix_valid; prev_ready = rdy; prev_data = pix_data;
    end
    check("frame_done", done_cnt, 1);
    check("pix_count", exp_idx, NPIX);
    check("rd_count", rd_cnt, NL);
    repeat (20) begin
      @(negedge clk);
      output_wt_done = 1'b0; pix_ready = 1'b1;
      if (out_mem_rd_en || pix_valid || stream_done || stream_busy) bad++;
    end
    check("idle_quiet", bad, 0);
  endtask

  initial begin
    void'($urandom(32'd4242));
    reset = 1'b1; output_wt_done = 1'b0; pix_ready = 1'b0;
    fill_pattern();
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    run_frame(0);
    run_frame(1);
    fill_random();
    run_frame(2);
    fill_pattern();
    run_frame(3);
    run_frame(0);
    run_frame(4);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
